// File: rtl/conv_pkg.sv
// Shared widths and limits for the conv MAC path.
// Imported by the accumulator, its interface and round_sat.
package conv_pkg;
  localparam int DATA_W = 18;
  localparam int FRAC   = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int WC_W   = 13;

  localparam logic signed [DATA_W-1:0] SAT_MAX =
    18'sh1FFFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN =
    18'sh20000;
endpackage

// File: rtl/conv_accumulator_if.sv
// Operand stream in, result strobe out.
// slave is the accumulator, master drives it.
interface conv_accumulator_if;
  import conv_pkg::*;

  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     in_en;
  logic signed [DATA_W-1:0] bias_in;
  logic                     bias_load;
  logic                     relu_en;
  logic                     clear;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_en;
  logic                     busy;
  logic [WC_W-1:0]          window_count;

  modport slave (
    input  in_a, in_b, in_en,
    input  bias_in, bias_load,
    input  relu_en, clear,
    output out_data, out_en,
    output busy, window_count
  );

  modport master (
    output in_a, in_b, in_en,
    output bias_in, bias_load,
    output relu_en, clear,
    input  out_data, out_en,
    input  busy, window_count
  );
endinterface

// File: rtl/conv_accumulator_round_sat.sv
// Bias add, half-up rounding shift, ReLU, saturation.
// Purely combinational so pooling stages can reuse it.
module round_sat
  import conv_pkg::*;
#(
  parameter int FRAC  = conv_pkg::FRAC,
  parameter int ACC_W = 2 * conv_pkg::DATA_W + 8
) (
  input  logic signed [ACC_W-1:0]  sum,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] res
);
  localparam int T_W = ACC_W + 2;

  localparam logic signed [T_W-1:0] RND =
    (T_W'(1) << FRAC) >>> 1;
  localparam logic signed [T_W-1:0] HI =
    T_W'(SAT_MAX);
  localparam logic signed [T_W-1:0] LO =
    T_W'(SAT_MIN);

  logic signed [T_W-1:0] bias_x;
  logic signed [T_W-1:0] t;
  logic signed [T_W-1:0] r;
  logic signed [T_W-1:0] v;

  assign bias_x = T_W'(bias) <<< FRAC;
  assign t = T_W'(sum) + bias_x + RND;
  assign r = t >>> FRAC;

  // clamp negatives if asked, then saturate
  always_comb begin
    v = r;
    if (relu_en && r < 0)
      v = '0;
    res = v[DATA_W-1:0];
    if (v > HI)
      res = SAT_MAX;
    else if (v < LO)
      res = SAT_MIN;
  end
endmodule

// File: rtl/conv_accumulator.sv
// Three-stage MAC: multiply, accumulate TERMS, finalize.
// Feeds the writeback stage one strobe per window.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int TERMS = 9,
  parameter int FRAC  = conv_pkg::FRAC,
  parameter int ACC_W = 2 * conv_pkg::DATA_W + 8
) (
  input logic clk,
  input logic rst,
  conv_accumulator_if.slave bus
);
  localparam logic [8:0] LAST = 9'(TERMS - 1);

  logic signed [PROD_W-1:0] prod_r;
  logic                     prod_v;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  sum_r;
  logic                     sum_v;
  logic [8:0]               cnt;
  logic signed [DATA_W-1:0] bias_r;
  logic signed [DATA_W-1:0] res;
  logic signed [DATA_W-1:0] out_data_r;
  logic                     out_en_r;
  logic [WC_W-1:0]          wc_r;

  assign acc_nxt = (cnt == '0)
    ? ACC_W'(prod_r)
    : acc + ACC_W'(prod_r);

  // S1: register the product of the incoming pair
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r <= '0;
      prod_v <= 1'b0;
    end else begin
      prod_r <= PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
      prod_v <= bus.in_en & ~bus.clear;
    end
  end

  // S2: accumulate; hand off the sum on the last term
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      sum_r <= '0;
      sum_v <= 1'b0;
      cnt   <= '0;
    end else if (bus.clear) begin
      cnt   <= '0;
      sum_v <= 1'b0;
    end else if (prod_v) begin
      acc <= acc_nxt;
      if (cnt == LAST) begin
        sum_r <= acc_nxt;
        sum_v <= 1'b1;
        cnt   <= '0;
      end else begin
        sum_v <= 1'b0;
        cnt   <= cnt + 9'd1;
      end
    end else begin
      sum_v <= 1'b0;
    end
  end

  // bias register; finalize at the same edge sees old value
  always_ff @(posedge clk) begin
    if (rst)
      bias_r <= '0;
    else if (bus.bias_load)
      bias_r <= bus.bias_in;
  end

  round_sat #(
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_round_sat (
    .sum     (sum_r),
    .bias    (bias_r),
    .relu_en (bus.relu_en),
    .res     (res)
  );

  // S3: latch the finished result and pulse the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r <= '0;
      out_en_r   <= 1'b0;
      wc_r       <= '0;
    end else if (sum_v) begin
      out_data_r <= res;
      out_en_r   <= 1'b1;
      wc_r       <= wc_r + 1'b1;
    end else begin
      out_en_r   <= 1'b0;
    end
  end

  assign bus.out_data     = out_data_r;
  assign bus.out_en       = out_en_r;
  assign bus.window_count = wc_r;
  assign bus.busy = (cnt != '0) | prod_v | sum_v;
endmodule

// File: tb/tb_conv_accumulator.sv
// Scoreboard bench for conv_accumulator.
// Expected results queued at drive time, popped on out_en.
module tb_conv_accumulator;
  import conv_pkg::*;

  localparam int TERMS = 9;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_accumulator_if bus();

  conv_accumulator #(
    .TERMS (TERMS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  exp_t   q[$];
  longint m_acc  = 0;
  int     m_cnt  = 0;
  longint m_bias = 0;
  logic   m_relu = 1'b0;
  int     m_wc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  function automatic longint model(input longint s,
                                   input longint b,
                                   input logic relu);
    longint t;
    longint r;
    t = s + b * 256 + 128;
    r = t >>> 8;
    if (relu && r < 0) r = 0;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  task automatic tick(input logic en, input int a,
                      input int b, input logic clr);
    logic [31:0] av;
    logic [31:0] bv;
    longint p;
    av = a;
    bv = b;
    bus.in_a  = av[17:0];
    bus.in_b  = bv[17:0];
    bus.in_en = en;
    bus.clear = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      m_cnt = 0;
    end else if (en) begin
      p = longint'(a) * longint'(b);
      m_acc = (m_cnt == 0) ? p : m_acc + p;
      m_cnt++;
      if (m_cnt == TERMS) begin
        q.push_back('{model(m_acc, m_bias, m_relu),
                      cyc + 2});
        m_cnt = 0;
      end
    end
    bus.in_en = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  task automatic terms(input int a, input int b,
                       input int n);
    for (int i = 0; i < n; i++) tick(1, a, b, 0);
  endtask

  task automatic load_bias(input int b);
    logic [31:0] bv;
    bv = b;
    bus.bias_in   = bv[17:0];
    bus.bias_load = 1'b1;
    idle(1);
    bus.bias_load = 1'b0;
    m_bias = b;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_en) begin
      if (q.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        check("data", longint'(bus.out_data), e.val);
        check("when", cyc, e.due);
        m_wc = (m_wc + 1) % 8192;
        check("wcount", bus.window_count, m_wc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_en = 1'b0;
    bus.bias_in = '0;
    bus.bias_load = 1'b0;
    bus.relu_en = 1'b0;
    bus.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", longint'(bus.out_data), 0);
    check("rst_en", bus.out_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wc", bus.window_count, 0);
    rst = 1'b0;
    idle(2);

    terms(256, 256, 3);
    check("busy_mid", bus.busy, 1);
    terms(256, 256, 6);
    idle(4);
    check("idle_busy", bus.busy, 0);

    load_bias(100);
    terms(256, 256, 9);
    idle(4);
    load_bias(0);
    terms(1, 128, 9);
    terms(-1, 128, 9);
    idle(4);

    terms(-256, 256, 9);
    idle(4);
    bus.relu_en = 1'b1;
    m_relu = 1'b1;
    terms(-256, 256, 9);
    idle(4);
    bus.relu_en = 1'b0;
    m_relu = 1'b0;

    terms(131071, 131071, 9);
    terms(131071, -131072, 9);
    idle(4);

    terms(256, 256, 18);
    idle(4);
    terms(256, 256, 4);
    idle(3);
    terms(256, 256, 5);
    idle(4);

    terms(256, 256, 4);
    tick(1, 256, 256, 1);
    check("busy_clr", bus.busy, 0);
    terms(256, 256, 9);
    idle(4);

    terms(3, 512, 9);
    idle(1);
    tick(0, 0, 0, 1);
    idle(4);

    terms(256, 256, 5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_cnt = 0;
    m_wc = 0;
    check("rst2_busy", bus.busy, 0);
    check("rst2_wc", bus.window_count, 0);
    terms(256, 256, 9);
    idle(6);

    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
